// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: register-file write port merge.
// Single-cycle ALU results have strict priority. Long-latency results come in
// through a valid/ready handshake, wait in an in-order FIFO, and drain on any
// edge where no ALU write is requested. The chosen write is registered, so it
// appears one cycle after the selecting edge.
// Optional feature: define WB_SCOREBOARD_EN to add the PendingMask output,
// which has one bit per register that still has a write waiting in the FIFO.
module wb_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          AluWrEn,
  input  logic [ADDR_W-1:0]             AluWrReg,
  input  logic [DATA_W-1:0]             AluWrData,
  input  logic                          LongValid,
  output logic                          LongReady,
  input  logic [ADDR_W-1:0]             LongWrReg,
  input  logic [DATA_W-1:0]             LongWrData,
  output logic                          RegWriteEn,
  output logic [ADDR_W-1:0]             WriteReg,
  output logic [DATA_W-1:0]             WriteData,
`ifdef WB_SCOREBOARD_EN
  output logic [2**ADDR_W-1:0]          PendingMask,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   FifoCount
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_reg_q  [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_reg_d  [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_reg_q,  wr_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic alu_req, push, pop, ready;

  // Ready depends only on registered occupancy. A full FIFO does not
  // accept a new entry on an edge where it pops.
  assign ready   = (count_q < CNT_W'(FIFO_DEPTH));
  assign alu_req = AluWrEn && (AluWrReg != '0);
  assign pop     = !alu_req && (count_q != '0);
  // Results for register 0 finish the handshake but are dropped.
  assign push    = LongValid && ready && (LongWrReg != '0);

  // FIFO pointer, occupancy and storage update.
  always_comb begin
    mem_reg_d  = mem_reg_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_reg_d[wr_ptr_q]  = LongWrReg;
      mem_data_d[wr_ptr_q] = LongWrData;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Output selection: ALU, then FIFO head, otherwise idle. Address and data
  // keep their last values while idle.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (alu_req) begin
      wr_en_d   = 1'b1;
      wr_reg_d  = AluWrReg;
      wr_data_d = AluWrData;
    end else if (pop) begin
      wr_en_d   = 1'b1;
      wr_reg_d  = mem_reg_q[rd_ptr_q];
      wr_data_d = mem_data_q[rd_ptr_q];
    end
  end

  // State registers; asynchronous reset drops buffered and in-flight writes.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_reg_q[i]  <= '0;
        mem_data_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      mem_reg_q  <= mem_reg_d;
      mem_data_q <= mem_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      wr_reg_q   <= wr_reg_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign LongReady  = ready;
  assign RegWriteEn = wr_en_q;
  assign WriteReg   = wr_reg_q;
  assign WriteData  = wr_data_q;
  assign FifoCount  = count_q;

`ifdef WB_SCOREBOARD_EN
  logic [2**ADDR_W-1:0] mask_c;
  logic [PTR_W-1:0]     off;

  // Mark the destination of each occupied slot. A slot is occupied when its
  // distance from the read pointer, modulo the depth, is below the count.
  always_comb begin
    mask_c = '0;
    off    = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if ({1'b0, off} < count_q) mask_c[mem_reg_q[i]] = 1'b1;
    end
    mask_c[0] = 1'b0;
  end

  assign PendingMask = mask_c;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Testbench for wb_write_arbiter: directed scenarios plus random traffic.
// The reference keeps the long-result buffer as a queue. Each write it predicts
// is queued with its due cycle, and a negedge monitor checks the DUT against
// that queue.
module tb_wb_write_arbiter;
  localparam int DW = 32, AW = 5, DEPTH = 4;

  logic          Clk = 0, Rst_n = 0;
  logic          AluWrEn = 0, LongValid = 0;
  logic [AW-1:0] AluWrReg = 0, LongWrReg = 0;
  logic [DW-1:0] AluWrData = 0, LongWrData = 0;
  logic          LongReady, RegWriteEn;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData;
  logic [2:0]    FifoCount;
`ifdef WB_SCOREBOARD_EN
  logic [31:0]   PendingMask;
`endif

  wb_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .AluWrEn(AluWrEn), .AluWrReg(AluWrReg), .AluWrData(AluWrData),
    .LongValid(LongValid), .LongReady(LongReady),
    .LongWrReg(LongWrReg), .LongWrData(LongWrData),
    .RegWriteEn(RegWriteEn), .WriteReg(WriteReg), .WriteData(WriteData),
`ifdef WB_SCOREBOARD_EN
    .PendingMask(PendingMask),
`endif
    .FifoCount(FifoCount));

  always #5 Clk = ~Clk;

  typedef struct { logic [AW-1:0] r; logic [DW-1:0] d; } ent_t;
  typedef struct { logic [AW-1:0] r; logic [DW-1:0] d; int cyc; } wr_t;

  ent_t mq[$];     // reference contents of the long-result buffer
  wr_t  exp_q[$];  // writes predicted but not yet observed
  int   total = 0, bad = 0, cyc = 0;
  logic [AW-1:0] last_r = 0;
  logic [DW-1:0] last_d = 0;
  wr_t  mw;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: every write the DUT presents must be the next predicted one, on its due cycle.
  always @(negedge Clk) begin
    if (Rst_n) begin
      if (RegWriteEn) begin
        if (exp_q.size() == 0) chk("unexpected_write", {27'd0, WriteReg}, 64'hFFFF);
        else begin
          mw = exp_q.pop_front();
          chk("wr_reg", WriteReg, mw.r);
          chk("wr_data", WriteData, mw.d);
          chk("wr_cycle", cyc, mw.cyc);
          last_r = mw.r; last_d = mw.d;
        end
      end else begin
        chk("hold_reg", WriteReg, last_r);
        chk("hold_data", WriteData, last_d);
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          mw = exp_q.pop_front();
          chk("missed_write", 0, {27'd0, mw.r});
        end
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  function automatic logic [31:0] model_mask();
    logic [31:0] m = 0;
    foreach (mq[i]) m[mq[i].r] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction
`endif

  // Check the visible state, predict the next edge's effect, then step one cycle.
  task automatic cycle();
    wr_t w; ent_t e; bit rdy;
    rdy = (mq.size() < DEPTH);
    chk("long_ready", LongReady, rdy);
    chk("fifo_count", FifoCount, mq.size());
`ifdef WB_SCOREBOARD_EN
    chk("pending_mask", PendingMask, model_mask());
`endif
    if (AluWrEn && AluWrReg != 0) begin
      w.r = AluWrReg; w.d = AluWrData; w.cyc = cyc + 1; exp_q.push_back(w);
    end else if (mq.size() > 0) begin
      e = mq.pop_front(); w.r = e.r; w.d = e.d; w.cyc = cyc + 1; exp_q.push_back(w);
    end
    if (LongValid && rdy && LongWrReg != 0) begin
      e.r = LongWrReg; e.d = LongWrData; mq.push_back(e);
    end
    @(posedge Clk); @(negedge Clk); #1;
  endtask

  task automatic set_alu(input bit en, input logic [AW-1:0] r, input logic [DW-1:0] d);
    AluWrEn = en; AluWrReg = r; AluWrData = d;
  endtask

  task automatic set_long(input bit v, input logic [AW-1:0] r, input logic [DW-1:0] d);
    LongValid = v; LongWrReg = r; LongWrData = d;
  endtask

  task automatic idle(input int n);
    set_alu(0, 0, 0); set_long(0, 0, 0);
    repeat (n) cycle();
  endtask

  task automatic async_reset();
    #2 Rst_n = 0;
    #1;
    chk("rst_wen", RegWriteEn, 0);
    chk("rst_count", FifoCount, 0);
    chk("rst_wreg", WriteReg, 0);
    chk("rst_wdata", WriteData, 0);
`ifdef WB_SCOREBOARD_EN
    chk("rst_mask", PendingMask, 0);
`endif
    mq.delete(); exp_q.delete(); last_r = 0; last_d = 0;
    set_alu(0, 0, 0); set_long(0, 0, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk); Rst_n = 1; #1;
  endtask

  int k, n_acc;
  logic [AW-1:0] regs[5];

  initial begin
    // Reset held for 3 edges, then idle.
    repeat (3) @(posedge Clk);
    #1;
    chk("init_wen", RegWriteEn, 0);
    chk("init_count", FifoCount, 0);
    chk("init_wreg", WriteReg, 0);
    chk("init_wdata", WriteData, 0);
    @(negedge Clk); Rst_n = 1; #1;
    idle(5);

    // ALU priority over a pending long result.
    set_long(1, 8, 32'hAAAA0001); cycle();
    set_long(0, 0, 0); set_alu(1, 9, 32'h12345678); cycle();
    idle(4);

    // Fill under continuous ALU writes, then drain in order.
    regs = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
    k = 0;
    set_alu(1, 3, 32'h33);
    for (int c = 0; c < 8; c++) begin
      if (k < 5) set_long(1, regs[k], {27'd0, regs[k]} * 32'h01010101);
      else set_long(0, 0, 0);
      if (k < 5 && mq.size() < DEPTH) begin cycle(); k++; end
      else cycle();
      set_alu(1, 3, 32'h33 + c);
    end
    set_alu(0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      if (k < 5) set_long(1, regs[k], {27'd0, regs[k]} * 32'h01010101);
      else set_long(0, 0, 0);
      if (k < 5 && mq.size() < DEPTH) begin cycle(); k++; end
      else cycle();
    end
    idle(3);

    // An ALU request to register 0 lets the FIFO drain; a long result to register 0 is dropped.
    set_alu(1, 7, 32'h77); set_long(1, 5, 32'h55555555); cycle();
    set_alu(1, 0, 32'hDEAD); set_long(0, 0, 0); cycle();
    set_alu(0, 0, 0); set_long(1, 0, 32'hBAD0); cycle();
    idle(3);

    // Streaming through the buffer with wrap-around: one push and one pop per edge.
    for (int r = 1; r <= 12; r++) begin
      set_long(1, r[AW-1:0], r * 32'h11); cycle();
    end
    idle(3);

    // Buffer 4,4,7 behind ALU writes, drain two entries, then reset asynchronously.
    set_alu(1, 3, 32'h1); set_long(1, 4, 32'h4000_0001); cycle();
    set_long(1, 4, 32'h4000_0002); cycle();
    set_long(1, 7, 32'h7000_0003); cycle();
    set_long(0, 0, 0); set_alu(1, 3, 32'h2); cycle();
    set_alu(0, 0, 0); cycle();
    cycle();
    async_reset();
    idle(5);

    // Random traffic, mostly valid destinations with some register 0 requests.
    n_acc = 0;
    for (int c = 0; c < 400; c++) begin
      set_alu(($urandom_range(0, 9) < 3), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom);
      set_long(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom), $urandom);
      if (LongValid && mq.size() < DEPTH) n_acc++;
      cycle();
    end
    idle(8);
    chk("drained_writes", exp_q.size(), 0);
    chk("random_accepts_seen", (n_acc > 0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer side of the register-file write port: merges writeback results from the single-cycle ALU path and a long-latency unit (mult/div or load) into one registered RegWriteEn/WriteReg/WriteData triple.
- Long-latency results enter through a valid/ready handshake into a small in-order FIFO.
- ALU writes have strict priority.
- Sits between the execute/memory stages and the register file in the multicycle datapath.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register address width.
- FIFO_DEPTH, 4, long-result buffer entries; power of 2, minimum 2.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- AluWrEn  in  1  ALU result to write this cycle; always accepted, no back-pressure.
- AluWrReg  in  ADDR_W  ALU destination register.
- AluWrData  in  DATA_W  ALU result.
- LongValid  in  1  long-unit result offered.
- LongReady  out  1  buffer can accept; transfer occurs when LongValid && LongReady at the rising edge.
- LongWrReg  in  ADDR_W  long-unit destination register.
- LongWrData  in  DATA_W  long-unit result.
- RegWriteEn  out  1  registered write enable to the register file.
- WriteReg  out  ADDR_W  registered write address.
- WriteData  out  DATA_W  registered write data.
- FifoCount  out  $clog2(FIFO_DEPTH)+1  buffered entries.

Behaviour:
- Reset (Rst_n low, asynchronous): RegWriteEn=0, WriteReg=0, WriteData=0, FIFO emptied (FifoCount=0), LongReady=1 once Rst_n is high.
  - Reset mid-operation discards all buffered entries and any in-flight output.
- Output selection, evaluated each rising edge, registered with 1-cycle latency:
  - ALU: if AluWrEn=1 and AluWrReg!=0, the outputs take the ALU triple.
  - FIFO: else, if FifoCount>0, pop the head; outputs take the head triple.
  - Idle: else RegWriteEn=0; WriteReg and WriteData hold their previous values.
- Register 0:
  - An ALU request to register 0 is treated as no request, and the FIFO may drain that cycle.
  - A long result to register 0 completes the handshake but is discarded, not pushed.
- LongReady = (FifoCount < FIFO_DEPTH), combinational from registered state only. No same-cycle pop-through: when full, LongReady=0 even on a pop cycle.
- Push and pop in the same cycle: FifoCount is unchanged; pointers advance modulo FIFO_DEPTH (wrap-around).
- No empty-FIFO bypass: an accepted long result reaches RegWriteEn no earlier than 2 edges after acceptance.
- Ordering: long results are written in acceptance order.
- No ALU/long ordering is enforced. Hazard avoidance belongs to the issuing pipeline (see optional feature).
- Starvation: continuous ALU writes stall FIFO draining indefinitely. The FIFO then fills and LongReady drops; this is required behaviour.
- Inputs are sampled only at rising edges; LongWrReg/LongWrData need only be stable when LongValid=1.

Optional Feature:
- Macro: WB_SCOREBOARD_EN.
- Defined:
  - Adds output PendingMask [2**ADDR_W-1:0].
  - Bit r=1 iff at least one valid FIFO entry targets register r; bit 0 is always 0.
  - Combinational from FIFO contents; it clears in the cycle after the last entry for r pops.
  - The pipeline uses it to stall issue of instructions reading or writing r.
  - Reset value is all zeros.
- Not defined: the port is absent and there is no scoreboard logic. All other behaviour is identical.

Test Plan:
- Reset then idle:
  - Hold Rst_n=0 for 3 cycles, release, drive no requests for 5 cycles.
  - Expect RegWriteEn=0, FifoCount=0, LongReady=1 throughout; WriteReg=0, WriteData=0.
- ALU priority with FIFO drain:
  - Push long (reg 8, 0xAAAA0001), then next cycle drive ALU (reg 9, 0x12345678) for 1 cycle.
  - Expect write reg 9=0x12345678 first, then reg 8=0xAAAA0001 on the following cycle.
- FIFO fill and back-pressure:
  - Hold AluWrEn=1 (reg 3) continuously and offer 5 long results (regs 10..14).
  - Expect 4 accepted, LongReady=0 with FifoCount=4.
  - After AluWrEn drops: writes to 10,11,12,13 in order on consecutive cycles, LongReady high after the first pop, then 14 accepted and written.
- Register 0 handling:
  - ALU reg 0 together with a FIFO entry pending for reg 5: expect the reg 5 write, no write to reg 0.
  - Long reg 0 offered: handshake completes, FifoCount unchanged, no write.
- Wrap-around and simultaneous push/pop:
  - Stream 12 long results (regs 1..12, data = reg*0x11) with LongValid held high and no ALU traffic.
  - Expect FifoCount steady at 1, each written exactly once in order, 2-cycle latency each.
- Async reset mid-operation, plus scoreboard when WB_SCOREBOARD_EN is defined:
  - With 3 entries buffered (regs 4,4,7), expect PendingMask=0x00000090.
  - After the first reg 4 pop, mask is still 0x90; after the second pop, 0x80.
  - Assert Rst_n low mid-sequence: mask, FifoCount and RegWriteEn go to 0 immediately, with no further writes.
